// File: rtl/conv_sched.sv
// Convolution-stage scheduler: admits one frame, replays it once per filter,
// tags recycler windows with filter/window indices and prefetches weight sets.
module conv_sched #(
  parameter int FRAME_LEN   = 50,
  parameter int NUM_FILTERS = 8,
  parameter int FILTER_LEN  = 3,
  localparam int WINDOWS    = FRAME_LEN - FILTER_LEN + 1,
  localparam int FBW        = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
  localparam int WBW        = (WINDOWS > 1) ? $clog2(WINDOWS) : 1
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           in_valid_i,
  input  logic           in_last_i,
  output logic           in_ready_o,
  output logic           rcy_valid_o,
  output logic           rcy_last_o,
  input  logic           rcy_win_valid_i,
  output logic           wt_rd_en_o,
  output logic [FBW-1:0] wt_addr_o,
  output logic           win_valid_o,
  output logic [FBW-1:0] filter_idx_o,
  output logic [WBW-1:0] win_idx_o,
  output logic           filter_last_o,
  output logic           last_o,
  output logic           busy_o,
  output logic [1:0]     err_o
);

  localparam int EBW = $clog2(FRAME_LEN + 1);
  localparam logic [FBW-1:0] FILT_MAX = FBW'(NUM_FILTERS - 1);
  localparam logic [WBW-1:0] WIN_MAX  = WBW'(WINDOWS - 1);
  localparam logic [EBW-1:0] ELEM_MAX = EBW'(FRAME_LEN);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_PROCESS = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [EBW-1:0] elem_q, elem_d;
  logic [WBW-1:0] win_q, win_d;
  logic [FBW-1:0] filt_q, filt_d;
  logic [1:0]     err_q, err_d;
  logic           wt_en_q, wt_en_d;
  logic [FBW-1:0] wt_addr_q, wt_addr_d;
  logic           tag_v_q, tag_v_d;
  logic [FBW-1:0] fidx_q, fidx_d;
  logic [WBW-1:0] widx_q, widx_d;
  logic           flast_q, flast_d;
  logic           last_q, last_d;
  logic           busy_q, busy_d;

  assign in_ready_o    = (state_q != S_PROCESS);
  assign rcy_valid_o   = in_valid_i & in_ready_o;
  assign rcy_last_o    = in_valid_i & in_ready_o & in_last_i;
  assign wt_rd_en_o    = wt_en_q;
  assign wt_addr_o     = wt_addr_q;
  assign win_valid_o   = tag_v_q;
  assign filter_idx_o  = fidx_q;
  assign win_idx_o     = widx_q;
  assign filter_last_o = flast_q;
  assign last_o        = last_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;

  // Next-state, counter, tag and prefetch logic
  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    win_d     = win_q;
    filt_d    = filt_q;
    err_d     = err_q;
    wt_en_d   = 1'b0;
    wt_addr_d = wt_addr_q;
    tag_v_d   = 1'b0;
    fidx_d    = fidx_q;
    widx_d    = widx_q;
    flast_d   = 1'b0;
    last_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rcy_win_valid_i) begin
          err_d[1] = 1'b1;
        end else begin
          err_d[1] = err_q[1];
        end
        if (in_valid_i && in_last_i) begin
          state_d   = S_PROCESS;
          err_d[0]  = 1'b1;
          elem_d    = '0;
          wt_en_d   = 1'b1;
          wt_addr_d = '0;
        end else if (in_valid_i) begin
          state_d = S_LOAD;
          elem_d  = EBW'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (rcy_win_valid_i) begin
          err_d[1] = 1'b1;
        end else begin
          err_d[1] = err_q[1];
        end
        // A saturated count never equals FRAME_LEN-1, so over-long frames flag too
        if (in_valid_i && in_last_i) begin
          state_d   = S_PROCESS;
          err_d[0]  = err_q[0] | (elem_q != (ELEM_MAX - EBW'(1)));
          elem_d    = '0;
          wt_en_d   = 1'b1;
          wt_addr_d = '0;
        end else if (in_valid_i) begin
          elem_d = (elem_q == ELEM_MAX) ? ELEM_MAX : (elem_q + EBW'(1));
        end else begin
          elem_d = elem_q;
        end
      end
      S_PROCESS: begin
        if (rcy_win_valid_i) begin
          tag_v_d = 1'b1;
          fidx_d  = filt_q;
          widx_d  = win_q;
          if (win_q == WIN_MAX) begin
            flast_d = 1'b1;
            win_d   = '0;
            if (filt_q == FILT_MAX) begin
              last_d  = 1'b1;
              filt_d  = '0;
              state_d = S_IDLE;
            end else begin
              filt_d    = filt_q + FBW'(1);
              wt_en_d   = 1'b1;
              wt_addr_d = filt_q + FBW'(1);
            end
          end else begin
            win_d = win_q + WBW'(1);
          end
        end else begin
          win_d = win_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered-output update with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      elem_q    <= '0;
      win_q     <= '0;
      filt_q    <= '0;
      err_q     <= 2'b00;
      wt_en_q   <= 1'b0;
      wt_addr_q <= '0;
      tag_v_q   <= 1'b0;
      fidx_q    <= '0;
      widx_q    <= '0;
      flast_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      elem_q    <= elem_d;
      win_q     <= win_d;
      filt_q    <= filt_d;
      err_q     <= err_d;
      wt_en_q   <= wt_en_d;
      wt_addr_q <= wt_addr_d;
      tag_v_q   <= tag_v_d;
      fidx_q    <= fidx_d;
      widx_q    <= widx_d;
      flast_q   <= flast_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
    end
  end

endmodule
